// File: rtl/xcore_bpu_pkg.sv
// Shared definitions for the Xcore dynamic branch prediction unit:
// opcode constants, instruction classification, 2-bit counter encodings
// and the link-register test used by the return-address stack logic.
package xcore_bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IT_NONE = 2'd0,
        IT_B    = 2'd1,
        IT_JAL  = 2'd2,
        IT_JALR = 2'd3
    } instr_type_e;

    // Saturating direction counter states; bit 1 is the taken prediction.
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // x1 (ra) and x5 (t0) are the architectural link registers.
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/xcore_bpu_ras.sv
// Return-address stack: circular buffer with a saturating depth counter.
// A push when full overwrites the oldest entry. push together with a
// successful pop replaces the top entry in place (depth unchanged).
// Ports: bpu_clk, bpu_rst (sync, active-high), push, pop, push_data in;
//        top (current top entry), empty out.
module xcore_bpu_ras
    import xcore_bpu_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        bpu_clk,
    input  logic        bpu_rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]      mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;       // next write slot
    logic [PTR_W-1:0] top_ptr;
    logic [CNT_W-1:0] depth;
    logic             do_pop;

    assign top_ptr = ptr - PTR_W'(1);
    assign empty   = (depth == '0);
    assign top     = mem[top_ptr];
    assign do_pop  = pop && !empty;

    // Pointer and depth bookkeeping.
    always_ff @(posedge bpu_clk) begin
        if (bpu_rst) begin
            ptr   <= '0;
            depth <= '0;
        end else if (push && do_pop) begin
            ptr   <= ptr;
            depth <= depth;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (depth != CNT_W'(RAS_DEPTH)) begin
                depth <= depth + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr   <= top_ptr;
            depth <= depth - CNT_W'(1);
        end
    end

    // Entry storage; pop-then-push rewrites the current top.
    always_ff @(posedge bpu_clk) begin
        if (!bpu_rst && push) begin
            if (do_pop) begin
                mem[top_ptr] <= push_data;
            end else begin
                mem[ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/xcore_bpu_dyn.sv
// Dynamic branch prediction unit at the IF/ID boundary.
// B-type direction from a PC-indexed table of 2-bit saturating counters
// (trained from commit), JAL always taken, JALR returns from the RAS.
// Ports: bpu_clk, bpu_rst (sync, active-high); decode-side cur_instr_*,
//        instr_b_off, instr_jal_off; flush_valid, stall_valid; training
//        upd_valid/upd_pc/upd_taken; outputs bpu_jump_valid and
//        bpu_instr_adr (combinational, same cycle as decode inputs).
module xcore_bpu_dyn
    import xcore_bpu_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input  logic        bpu_clk,
    input  logic        bpu_rst,
    input  logic [31:0] cur_instr_pc,
    input  logic [6:0]  cur_instr_op,
    input  logic [4:0]  cur_instr_rd,
    input  logic [4:0]  cur_instr_rs1,
    input  logic [12:0] instr_b_off,
    input  logic [20:0] instr_jal_off,
    input  logic        flush_valid,
    input  logic        stall_valid,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        bpu_jump_valid,
    output logic [31:0] bpu_instr_adr
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic             bpu_stop;
    logic             suppress;
    instr_type_e      itype;
    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             rd_link;
    logic             rs1_link;
    logic [31:0]      pc_plus4;
    logic [31:0]      b_target;
    logic [31:0]      jal_target;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ras_push;
    logic             ras_pop;
    logic [31:0]      ras_top;
    logic             ras_empty;
    logic             unused_upd_pc_bits;

    assign cur_idx    = cur_instr_pc[IDX_W+1:2];
    assign upd_idx    = upd_pc[IDX_W+1:2];
    assign rd_link    = is_link(cur_instr_rd);
    assign rs1_link   = is_link(cur_instr_rs1);
    assign pc_plus4   = cur_instr_pc + 32'd4;
    assign b_target   = cur_instr_pc + {{19{instr_b_off[12]}}, instr_b_off};
    assign jal_target = cur_instr_pc + {{11{instr_jal_off[20]}}, instr_jal_off};
    assign suppress   = flush_valid | stall_valid | bpu_stop;
    assign unused_upd_pc_bits = ^{upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Instruction-type decode.
    always_comb begin
        itype = IT_NONE;
        case (cur_instr_op)
            OP_BRANCH: itype = IT_B;
            OP_JAL:    itype = IT_JAL;
            OP_JALR:   itype = IT_JALR;
            default:   itype = IT_NONE;
        endcase
    end

    // Direction, target and RAS action per instruction type.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pc_plus4;
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        case (itype)
            IT_B: begin
                pred_taken  = bht[cur_idx][1];
                pred_target = b_target;
            end
            IT_JAL: begin
                pred_taken  = 1'b1;
                pred_target = jal_target;
                ras_push    = rd_link;
            end
            IT_JALR: begin
                pred_taken  = rs1_link && !ras_empty;
                pred_target = ras_top;
                ras_push    = rd_link;
                // rd == rs1 (both link) is a plain push, not a swap.
                ras_pop     = rs1_link && !(rd_link && (cur_instr_rd == cur_instr_rs1));
            end
            default: begin
                pred_taken = 1'b0;
            end
        endcase
        if (suppress) begin
            ras_push = 1'b0;
            ras_pop  = 1'b0;
        end
    end

    assign bpu_jump_valid = pred_taken && !suppress;
    assign bpu_instr_adr  = pred_taken ? pred_target : pc_plus4;

    // Stop flag delays resumption one cycle after a flush or stall.
    always_ff @(posedge bpu_clk) begin
        if (bpu_rst) begin
            bpu_stop <= 1'b0;
        end else begin
            bpu_stop <= flush_valid | stall_valid;
        end
    end

    // Counter table training; lookups this cycle still see the old value.
    always_ff @(posedge bpu_clk) begin
        if (bpu_rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (bht[upd_idx] != CTR_ST) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                end
            end else if (bht[upd_idx] != CTR_SNT) begin
                bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

    xcore_bpu_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .bpu_clk   (bpu_clk),
        .bpu_rst   (bpu_rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule
